// File: rtl/fc_sched_pkg.sv
// Shared types and elaboration-time helpers for the FC / conv MAC schedulers.
// Latency: n/a (package only).
// Backpressure: n/a. Holds the FSM state enum, clog2/ceil_div/sat_dw and the
// lane/chunk constants of the default FC configuration (PE_NUM=8, IN_LEN=120).
package fc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  localparam int FC_PE_NUM     = 8;
  localparam int FC_IN_LEN     = 120;
  localparam int FC_LANES      = 2 * FC_PE_NUM;
  localparam int FC_CHUNKS     = ceil_div(FC_IN_LEN, FC_LANES);
  localparam int FC_LAST_VALID = FC_IN_LEN - (FC_CHUNKS - 1) * FC_LANES;

endpackage

// File: rtl/fc_lane_reducer.sv
// Masked signed adder tree over LANES DWIDTH-bit lane products.
// Latency: combinational, 0 cycles.
// Backpressure: none; lanes with index >= lane_cnt contribute 0.
// Ports: lanes (packed lane products, lane 0 in LSBs), lane_cnt (active lane
// count, 0..LANES), sum (signed, DWIDTH+clog2(LANES) bits, cannot overflow).
module fc_lane_reducer
  import fc_sched_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int LANES  = 16,
  localparam int CNT_W = clog2(LANES) + 1,
  localparam int SUM_W = DWIDTH + clog2(LANES)
) (
  input  logic [LANES*DWIDTH-1:0] lanes,
  input  logic [CNT_W-1:0]        lane_cnt,
  output logic signed [SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane_cnt)) begin
        sum = sum + SUM_W'($signed(lanes[i*DWIDTH +: DWIDTH]));
      end
    end
  end

endmodule

// File: rtl/fc_mac_scheduler.sv
// Sequences one FC layer over the 2*PE_NUM-lane multiplier array, accumulating and saturating one result per neuron.
// Latency: CHUNKS + 1 + MULT_LAT + 1 cycles per neuron with res_ready high; result appears CHUNKS+MULT_LAT+1 cycles after the first read.
// Backpressure: res_valid/res_ready handshake; no reads are issued while a result waits, so stalls never disturb the accumulator.
// Build option: FC_RELU_EN (defined: negative saturated results become 0; undefined: signed result passes unchanged).
// Ports: clk/rst_n (async active-low); start pulse; rd_en, din_addr, w_addr to the input/weight buffers;
//        mult_dout lane products back from the multiplier list; res_data/res_valid/res_ready/res_idx result handshake;
//        busy (layer in progress), done (one-cycle pulse after the last result is accepted).
module fc_mac_scheduler
  import fc_sched_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int PE_NUM   = 8,
  parameter int IN_LEN   = 120,
  parameter int OUT_LEN  = 84,
  parameter int MULT_LAT = 1,
  parameter int ACC_W    = 32,
  parameter int ADDR_W   = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          din_addr,
  output logic [ADDR_W-1:0]          w_addr,
  input  logic [2*PE_NUM*DWIDTH-1:0] mult_dout,
  output logic [DWIDTH-1:0]          res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ADDR_W-1:0]          res_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int LANES      = 2 * PE_NUM;
  localparam int CHUNKS     = ceil_div(IN_LEN, LANES);
  localparam int LAST_VALID = IN_LEN - (CHUNKS - 1) * LANES;
  localparam int PIPE_D     = 1 + MULT_LAT;  // buffer read + multiplier
  localparam int SUM_W      = DWIDTH + clog2(LANES);
  localparam int CNT_W      = clog2(LANES) + 1;

  localparam logic [ADDR_W-1:0] LAST_CHUNK  = ADDR_W'(CHUNKS - 1);
  localparam logic [ADDR_W-1:0] LAST_NEURON = ADDR_W'(OUT_LEN - 1);

  fc_state_e state_q, state_d;

  logic [ADDR_W-1:0]       chunk_q;
  logic [ADDR_W-1:0]       neuron_q;
  logic [ADDR_W-1:0]       w_cnt_q;      // neuron*CHUNKS + chunk, kept as a running count
  logic [PIPE_D-1:0]       tag_vld_q;
  logic [PIPE_D-1:0]       tag_last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DWIDTH-1:0]       res_data_q;
  logic                    res_valid_q;
  logic [ADDR_W-1:0]       res_idx_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    issue;
  logic                    last_chunk;
  logic                    tag_exit;
  logic                    tag_exit_last;
  logic                    accept;
  logic [CNT_W-1:0]        lane_cnt;
  logic signed [SUM_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_sum;
  logic [DWIDTH-1:0]       res_sat;
  logic [DWIDTH-1:0]       res_nxt;

  assign issue         = (state_q == FEED);
  assign last_chunk    = (chunk_q == LAST_CHUNK);
  assign tag_exit      = tag_vld_q[PIPE_D-1];
  assign tag_exit_last = tag_exit & tag_last_q[PIPE_D-1];
  assign accept        = (state_q == OUT) & res_valid_q & res_ready;

  // The tail chunk only carries LAST_VALID real lanes; the rest hold stale data.
  assign lane_cnt = tag_last_q[PIPE_D-1] ? CNT_W'(LAST_VALID) : CNT_W'(LANES);

  fc_lane_reducer #(
    .DWIDTH (DWIDTH),
    .LANES  (LANES)
  ) u_reducer (
    .lanes    (mult_dout),
    .lane_cnt (lane_cnt),
    .sum      (lane_sum)
  );

  assign acc_sum = acc_q + {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
  assign res_sat = DWIDTH'(sat_dw(64'(acc_sum), DWIDTH));

  always_comb begin
    res_nxt = res_sat;
`ifdef FC_RELU_EN
    // After clamping into DWIDTH range the MSB is the sign.
    if (res_sat[DWIDTH-1]) res_nxt = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)         state_d = FEED;
      FEED:    if (last_chunk)    state_d = DRAIN;
      DRAIN:   if (tag_exit_last) state_d = OUT;
      OUT:     if (accept)        state_d = (neuron_q == LAST_NEURON) ? IDLE : FEED;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_q     <= '0;
      neuron_q    <= '0;
      w_cnt_q     <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      tag_vld_q  <= {tag_vld_q[PIPE_D-2:0], issue};
      tag_last_q <= {tag_last_q[PIPE_D-2:0], issue & last_chunk};
      if (tag_exit) acc_q <= acc_sum;

      case (state_q)
        IDLE: begin
          if (start) begin
            neuron_q <= '0;
            chunk_q  <= '0;
            w_cnt_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        FEED: begin
          chunk_q <= chunk_q + ADDR_W'(1);
          w_cnt_q <= w_cnt_q + ADDR_W'(1);
        end
        DRAIN: begin
          if (tag_exit_last) begin
            res_data_q  <= res_nxt;
            res_valid_q <= 1'b1;
            res_idx_q   <= neuron_q;
          end
        end
        OUT: begin
          if (accept) begin
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            if (neuron_q != LAST_NEURON) begin
              neuron_q <= neuron_q + ADDR_W'(1);
              chunk_q  <= '0;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = issue;
  assign din_addr  = issue ? chunk_q : '0;
  assign w_addr    = issue ? w_cnt_q : '0;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fc_mac_scheduler.sv
// Directed bench for fc_mac_scheduler: IN_LEN=120 (8 chunks of 16 lanes, 8 valid in the tail), OUT_LEN=3, MULT_LAT=1.
// The multiplier list is modelled as a 2-cycle delay of the issued addresses feeding a per-mode lane pattern.
module tb_fc_mac_scheduler;

  localparam int DW   = 16;
  localparam int PE   = 8;
  localparam int LN   = 2 * PE;
  localparam int OUTL = 3;
  localparam int AW   = 10;
  localparam int LAT  = 10;  // first rd_en to res_valid: 8 chunks + read + multiply

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            rd_en;
  logic [AW-1:0]   din_addr;
  logic [AW-1:0]   w_addr;
  logic [LN*DW-1:0] mult_dout;
  logic [DW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready;
  logic [AW-1:0]   res_idx;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  fc_mac_scheduler #(
    .DWIDTH(DW), .PE_NUM(PE), .IN_LEN(120), .OUT_LEN(OUTL),
    .MULT_LAT(1), .ACC_W(32), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en),
    .din_addr(din_addr), .w_addr(w_addr), .mult_dout(mult_dout),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .busy(busy), .done(done)
  );

  // ---------------- multiplier-list model ----------------
  int            mode;
  logic          p1_vld, p2_vld;
  logic [AW-1:0] p1_din, p2_din, p1_w, p2_w;

  always @(posedge clk) begin
    p1_vld <= rd_en;   p1_din <= din_addr; p1_w <= w_addr;
    p2_vld <= p1_vld;  p2_din <= p1_din;   p2_w <= p1_w;
  end

  // 0: all ones, tail lanes 8..15 = 100; 1: 0x7FFF; 2: 0x8000; 3: lane = w_addr; 4: -1.
  // Untagged cycles carry junk that must never reach the accumulator.
  function automatic logic [15:0] lane_val(input int m, input logic v, input logic [AW-1:0] d,
                                           input logic [AW-1:0] w, input int l);
    if (!v) return 16'h0033;
    case (m)
      0:       return (d == 10'd7 && l >= 8) ? 16'd100 : 16'd1;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return {6'd0, w};
      default: return 16'hFFFF;
    endcase
  endfunction

  always_comb begin
    mult_dout = '0;
    for (int l = 0; l < LN; l++) mult_dout[l*DW +: DW] = lane_val(mode, p2_vld, p2_din, p2_w, l);
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] din_q[$];
  logic [AW-1:0] w_q[$];
  int            done_cnt;

  always @(negedge clk) begin
    if (rd_en) begin
      din_q.push_back(din_addr);
      w_q.push_back(w_addr);
    end
    if (done) done_cnt++;
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          mode;
    int          stall;
    bit          busy_start;
    logic [15:0] e0, e1, e2;
  } tv_t;

  tv_t tv[5];

  function automatic logic [15:0] exp_of(input tv_t t, input int n);
    return (n == 0) ? t.e0 : (n == 1) ? t.e1 : t.e2;
  endfunction

  task automatic run_pass(input tv_t t, input bit start_at_done);
    int waitc;
    int errs;
    bit stable;
    mode      = t.mode;
    res_ready = (t.stall == 0);
    din_q.delete();
    w_q.delete();
    done_cnt = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_rd_en", {busy, rd_en, din_addr, w_addr}, {1'b1, 1'b1, 20'd0});
    for (int n = 0; n < OUTL; n++) begin
      waitc = 0;
      if (n == 1 && t.busy_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitc = 1;
      end
      while (!res_valid && waitc < 40) begin
        @(negedge clk);
        waitc++;
      end
      chk("latency", waitc, LAT);
      chk("res_data", res_data, exp_of(t, n));
      chk("res_idx", res_idx, n);
      if (t.stall > 0) begin
        stable = 1'b1;
        for (int s = 0; s < t.stall; s++) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_data !== exp_of(t, n) || res_idx !== AW'(n) || rd_en !== 1'b0)
            stable = 1'b0;
        end
        chk("stall_hold", stable, 1);
        res_ready = 1'b1;
      end
      @(negedge clk);
      if (t.stall > 0) res_ready = 1'b0;
      chk("valid_drop", res_valid, 0);
      if (n < OUTL - 1) begin
        chk("next_rd_en", {rd_en, din_addr}, {1'b1, 10'd0});
      end else begin
        chk("done_pulse", {done, busy}, 2'b10);
        chk("rd_en_count", w_q.size(), OUTL * 8);
        errs = 0;
        for (int i = 0; i < w_q.size(); i++)
          if (w_q[i] !== AW'(i) || din_q[i] !== AW'(i % 8)) errs++;
        chk("addr_seq", errs, 0);
        if (start_at_done) begin
          mode  = 3;
          start = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk("done_once", done_cnt, 1);
    if (start_at_done) begin
      start = 1'b0;
      chk("start_in_done", {busy, rd_en, w_addr}, {1'b1, 1'b1, 10'd0});
    end else begin
      chk("done_low", done, 0);
    end
  endtask

  initial begin
    int waitc;
`ifdef FC_RELU_EN
    tv[0] = '{0, 0,  1'b0, 16'd120,  16'd120,  16'd120};
    tv[1] = '{3, 0,  1'b1, 16'd392,  16'd1352, 16'd2312};
    tv[2] = '{1, 2,  1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tv[3] = '{2, 10, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tv[4] = '{4, 0,  1'b0, 16'h0000, 16'h0000, 16'h0000};
`else
    tv[0] = '{0, 0,  1'b0, 16'd120,  16'd120,  16'd120};
    tv[1] = '{3, 0,  1'b1, 16'd392,  16'd1352, 16'd2312};
    tv[2] = '{1, 2,  1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tv[3] = '{2, 10, 1'b0, 16'h8000, 16'h8000, 16'h8000};
    tv[4] = '{4, 0,  1'b0, 16'hFF88, 16'hFF88, 16'hFF88};
`endif
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, din_addr, w_addr, res_data, res_valid, res_idx, busy, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {rd_en, busy, done, res_valid}, 0);

    for (int i = 0; i < 5; i++) run_pass(tv[i], i == 4);

    // Pass started in the done cycle: let neuron 0 finish, then reset inside neuron 1's FEED.
    res_ready = 1'b1;
    waitc = 0;
    while (!res_valid && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    chk("chain_latency", waitc, LAT);
    chk("chain_n0", {res_idx, res_data}, {10'd0, 16'd392});
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("feed_n1", {rd_en, din_addr, w_addr}, {1'b1, 10'd2, 10'd10});
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", {rd_en, din_addr, w_addr, res_data, res_valid, res_idx, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(tv[1], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
